// File: rtl/stage_if_pkg.sv
// Shared CPU definitions for the pipeline stages: fetch FSM encodings,
// the NOP word and the redirect alignment helper.
package stage_if_pkg;

  typedef enum logic [3:0] {
    s_INIT = 4'b0001,
    s_IF   = 4'b0010,
    s_IW   = 4'b0100,
    s_HOLD = 4'b1000
  } if_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/stage_if.sv
// Instruction fetch stage: one outstanding request at a time, redirect and
// squash from later stages, and a stall-aware hand-off of IR/PC_O to ID.
module stage_if
  import stage_if_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] PC,
  output logic        Inst_Req_Valid,
  input  logic        Inst_Req_Ready,
  input  logic [31:0] Instruction,
  input  logic        Inst_Valid,
  output logic        Inst_Ready,
  output logic [31:0] IR,
  output logic [31:0] PC_O,
  output logic        Done_O,
  input  logic [31:0] next_PC,
  input  logic        Feedback_Branch,
  input  logic        Feedback_Mem_Acc,
  output logic [31:0] Fetch_Cnt
);

  if_state_e state, state_next;
  logic      discard;
  logic      capture;
  logic      set_discard;
  logic      clr_discard;
  logic      done_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= s_INIT;
    else        state <= state_next;
  end

  // A response whose request was overtaken by a redirect is still consumed,
  // so the memory never sees a second request while one is in flight.
  always_comb begin
    state_next     = state;
    Inst_Req_Valid = 1'b0;
    Inst_Ready     = 1'b0;
    capture        = 1'b0;
    set_discard    = 1'b0;
    clr_discard    = 1'b0;
    done_clr       = 1'b0;
    case (state)
      s_INIT: state_next = s_IF;
      s_IF: begin
        Inst_Req_Valid = 1'b1;
        if (Inst_Req_Ready) begin
          state_next  = s_IW;
          set_discard = Feedback_Branch;
        end
      end
      s_IW: begin
        Inst_Ready = 1'b1;
        if (Inst_Valid) begin
          if (Feedback_Branch || discard) begin
            clr_discard = 1'b1;
            state_next  = s_IF;
          end else begin
            capture    = 1'b1;
            state_next = s_HOLD;
          end
        end else if (Feedback_Branch) begin
          set_discard = 1'b1;
        end
      end
      s_HOLD: begin
        if (Feedback_Branch || !Feedback_Mem_Acc) begin
          done_clr   = 1'b1;
          state_next = s_IF;
        end
      end
      default: state_next = s_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC        <= RESET_PC;
      IR        <= NOP_INST;
      PC_O      <= 32'h0;
      Done_O    <= 1'b0;
      Fetch_Cnt <= 32'h0;
      discard   <= 1'b0;
    end else begin
      if (Feedback_Branch) PC <= align_word(next_PC);
      else if (capture)    PC <= PC + 32'd4;

      if (capture) begin
        IR   <= Instruction;
        PC_O <= PC;
      end

      if (capture)       Done_O <= 1'b1;
      else if (done_clr) Done_O <= 1'b0;

      if (set_discard)      discard <= 1'b1;
      else if (clr_discard) discard <= 1'b0;

      // A delivery counts once ID actually takes it (not stalled).
      if (Done_O && !Feedback_Mem_Acc) Fetch_Cnt <= Fetch_Cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_stage_if.sv
// Self-checking bench for stage_if: directed scenarios then random traffic,
// all compared against a transaction-level model of the fetch stage.
module tb_stage_if;

  logic        clk;
  logic        rst_n;
  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Req_Ready;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ready;
  logic [31:0] IR;
  logic [31:0] PC_O;
  logic        Done_O;
  logic [31:0] next_PC;
  logic        Feedback_Branch;
  logic        Feedback_Mem_Acc;
  logic [31:0] Fetch_Cnt;

  int errors = 0;
  int checks = 0;

  // Model: what the fetch stage should be doing, in transaction terms.
  logic        m_started;
  logic        m_out;
  logic        m_drop;
  logic        m_done;
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic [31:0] m_pco;
  logic [31:0] m_cnt;

  stage_if dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .PC               (PC),
    .Inst_Req_Valid   (Inst_Req_Valid),
    .Inst_Req_Ready   (Inst_Req_Ready),
    .Instruction      (Instruction),
    .Inst_Valid       (Inst_Valid),
    .Inst_Ready       (Inst_Ready),
    .IR               (IR),
    .PC_O             (PC_O),
    .Done_O           (Done_O),
    .next_PC          (next_PC),
    .Feedback_Branch  (Feedback_Branch),
    .Feedback_Mem_Acc (Feedback_Mem_Acc),
    .Fetch_Cnt        (Fetch_Cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return {addr[15:0], ~addr[15:0]} ^ 32'h5A00_00A5;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_started = 1'b0;
    m_out     = 1'b0;
    m_drop    = 1'b0;
    m_done    = 1'b0;
    m_pc      = 32'h0;
    m_ir      = 32'h0000_0013;
    m_pco     = 32'h0;
    m_cnt     = 32'h0;
  endtask

  // One clock of the model, using the inputs held across the rising edge.
  task automatic modelStep();
    logic [31:0] pc_n;
    logic        out_n, drop_n, done_n;
    pc_n   = m_pc;
    out_n  = m_out;
    drop_n = m_drop;
    done_n = m_done;
    if (Feedback_Branch) pc_n = {next_PC[31:2], 2'b00};
    if (m_started && !m_out && !m_done && Inst_Req_Ready) begin
      out_n  = 1'b1;
      drop_n = Feedback_Branch;
    end else if (m_out && Inst_Valid) begin
      out_n  = 1'b0;
      drop_n = 1'b0;
      if (!(m_drop || Feedback_Branch)) begin
        m_ir   = memWord(m_pc);
        m_pco  = m_pc;
        done_n = 1'b1;
        pc_n   = m_pc + 32'd4;
      end
    end else if (m_out && Feedback_Branch) begin
      drop_n = 1'b1;
    end
    if (m_done) begin
      if (!Feedback_Mem_Acc) m_cnt = m_cnt + 32'd1;
      if (Feedback_Branch || !Feedback_Mem_Acc) done_n = 1'b0;
    end
    m_pc      = pc_n;
    m_out     = out_n;
    m_drop    = drop_n;
    m_done    = done_n;
    m_started = 1'b1;
  endtask

  task automatic checkCycle();
    checkOutput("pc",        PC,             m_pc);
    checkOutput("req_valid", 32'(Inst_Req_Valid), 32'(m_started && !m_out && !m_done));
    checkOutput("inst_rdy",  32'(Inst_Ready),     32'(m_out));
    checkOutput("done",      32'(Done_O),         32'(m_done));
    checkOutput("ir",        IR,             m_ir);
    checkOutput("pc_o",      PC_O,           m_pco);
    checkOutput("fetch_cnt", Fetch_Cnt,      m_cnt);
  endtask

  // Called at a falling edge: check, drive one cycle of inputs, advance.
  task automatic applyStimulus(input logic rdy, input logic vok, input logic br,
                               input logic macc, input logic [31:0] npc,
                               input logic fv);
    checkCycle();
    Inst_Req_Ready   = rdy;
    Inst_Valid       = (m_out && vok) || fv;
    Instruction      = Inst_Valid ? memWord(m_pc) : $urandom;
    Feedback_Branch  = br;
    next_PC          = npc;
    Feedback_Mem_Acc = macc;
    @(posedge clk);
    if (rst_n) modelStep();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    Inst_Req_Ready = 1'b0;
    Inst_Valid = 1'b0;
    Instruction = 32'h0;
    Feedback_Branch = 1'b0;
    next_PC = 32'h0;
    Feedback_Mem_Acc = 1'b0;
    modelReset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("reset_ir", IR, 32'h0000_0013);
    rst_n = 1'b1;

    // Memory always ready: two back-to-back deliveries, then a slow response.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("slow_pc", PC, 32'h8);
    checkOutput("slow_rdy", 32'(Inst_Ready), 32'h1);
    checkOutput("cnt_two", Fetch_Cnt, 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("third_ir", IR, memWord(32'h8));

    // Downstream stall for three cycles in the hold phase.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
    checkOutput("stall_done", 32'(Done_O), 32'h1);
    checkOutput("stall_cnt", Fetch_Cnt, 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("stall_release_cnt", Fetch_Cnt, 32'd3);

    // Redirect while waiting for the word: it must be dropped.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h103, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("redir_pc", PC, 32'h100);
    checkOutput("redir_done", 32'(Done_O), 32'h0);
    checkOutput("redir_cnt", Fetch_Cnt, 32'd3);

    // Fetch from the last word of the address space wraps to zero.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0);
    checkOutput("wrap_pre", PC, 32'hFFFF_FFFC);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("wrap_pc", PC, 32'h0);
    checkOutput("wrap_pco", PC_O, 32'hFFFF_FFFC);

    // Reset dropped while a request is outstanding; the late word is ignored.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("pre_rst_rdy", 32'(Inst_Ready), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_pc", PC, 32'h0);
    checkOutput("arst_ir", IR, 32'h0000_0013);
    checkOutput("arst_rdy", 32'(Inst_Ready), 32'h0);
    checkOutput("arst_cnt", Fetch_Cnt, 32'h0);
    modelReset();
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("restart_pco", PC_O, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) == 0),
                    $urandom, 1'b0);
    end
    checkCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
